// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial host issuer.
// The optional watchdog is enabled with FACT_TIMEOUT_EN.
package fact_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_RES_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } fact_state_e;

   localparam logic FLAG_SET = 1'b1;
   localparam logic FLAG_CLR = 1'b0;

endpackage

// File: rtl/fact_watchdog.sv
// Cycle counter for the WAIT state; expire fires on the cycle the count
// would reach TIMEOUT_CYC. Used only when FACT_TIMEOUT_EN is defined.
module fact_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && cnt_q != CNT_W'(TIMEOUT_CYC))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fact_host_issuer.sv
// Host-side start/done initiator for the factorial datapath; answers 0, 1 and
// operands above MAX_N locally. FACT_TIMEOUT_EN adds a missing-done watchdog.
module fact_host_issuer
   import fact_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RES_W       = DEF_RES_W,
   parameter int MAX_N       = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_n,
   output logic              start,
   output logic [DATA_W-1:0] dp_din,
   input  logic              done,
   input  logic [RES_W-1:0]  dp_dout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_data,
   output logic              rsp_ovf,
   output logic              rsp_err
);

   fact_state_e       state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] dp_din_q, dp_din_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
   logic              ovf_q, ovf_d;
   logic              wd_expire;

`ifdef FACT_TIMEOUT_EN
   logic err_q, err_d;

   fact_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_q != S_WAIT),
      .en     (state_q == S_WAIT),
      .expire (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      start_d     = 1'b0;
      dp_din_d    = dp_din_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      ovf_d       = ovf_q;
`ifdef FACT_TIMEOUT_EN
      err_d       = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_n <= DATA_W'(1)) begin
                  rsp_data_d  = RES_W'(1);
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end else if (req_n > DATA_W'(MAX_N)) begin
                  rsp_data_d  = '1;
                  ovf_d       = FLAG_SET;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end else begin
                  dp_din_d = req_n;
                  start_d  = 1'b1;
                  state_d  = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            // done wins over a watchdog expiry landing in the same cycle
            if (done) begin
               rsp_data_d  = dp_dout;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (wd_expire) begin
               rsp_data_d  = '0;
`ifdef FACT_TIMEOUT_EN
               err_d       = FLAG_SET;
`endif
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               ovf_d       = FLAG_CLR;
`ifdef FACT_TIMEOUT_EN
               err_d       = FLAG_CLR;
`endif
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b0;
         start_q     <= 1'b0;
         dp_din_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ovf_q       <= FLAG_CLR;
`ifdef FACT_TIMEOUT_EN
         err_q       <= FLAG_CLR;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         start_q     <= start_d;
         dp_din_q    <= dp_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ovf_q       <= ovf_d;
`ifdef FACT_TIMEOUT_EN
         err_q       <= err_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign start     = start_q;
   assign dp_din    = dp_din_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_ovf   = ovf_q;
`ifdef FACT_TIMEOUT_EN
   assign rsp_err   = err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fact_host_issuer.sv
// Scoreboard bench for fact_host_issuer with a behavioural datapath model.
// Timeout scenarios run only when FACT_TIMEOUT_EN is defined.
module tb_fact_host_issuer;

   localparam int DATA_W      = 8;
   localparam int RES_W       = 16;
   localparam int MAX_N       = 8;
   localparam int TIMEOUT_CYC = 64;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [DATA_W-1:0] req_n     = '0;
   logic              start;
   logic [DATA_W-1:0] dp_din;
   logic              done      = 1'b0;
   logic [RES_W-1:0]  dp_dout   = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [RES_W-1:0]  rsp_data;
   logic              rsp_ovf;
   logic              rsp_err;

   always #5 clk = ~clk;

   fact_host_issuer #(
      .DATA_W(DATA_W), .RES_W(RES_W), .MAX_N(MAX_N), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
      .start(start), .dp_din(dp_din), .done(done), .dp_dout(dp_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   typedef struct packed {
      logic [RES_W-1:0] data;
      logic             ovf;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   n_chk      = 0;
   int   n_fail     = 0;
   int   n_starts   = 0;
   int   exp_starts = 0;
   int   dp_lat     = 3;
   bit   dp_mute    = 1'b0;
   bit   job_killed = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RES_W-1:0] fact(input int n);
      logic [31:0] f;
      f = 32'd1;
      for (int i = 2; i <= n; i++) f = f * 32'(i);
      return f[RES_W-1:0];
   endfunction

   // Datapath controller model: sees start, holds for dp_lat cycles, pulses done.
   initial begin : dp_model
      int n;
      forever begin
         @(negedge clk);
         if (start === 1'b1) begin
            n_starts++;
            n = int'(dp_din);
            for (int i = 1; i <= dp_lat; i++) begin
               @(negedge clk);
               if (!job_killed) begin
                  if (i == 1) check("start_pulse", 32'(start), 32'd0);
                  check("dp_din_hold", 32'(dp_din), 32'(n));
               end
            end
            if (!dp_mute) begin
               done    = 1'b1;
               dp_dout = fact(n);
               @(negedge clk);
               done    = 1'b0;
            end
            job_killed = 1'b0;
         end
      end
   end

   task automatic send(input int n, input bit to_err);
      exp_t e;
      int   b;
      e.ovf = 1'b0;
      e.err = 1'b0;
      if (n <= 1) begin
         e.data = RES_W'(1);
      end else if (n > MAX_N) begin
         e.data = '1;
         e.ovf  = 1'b1;
      end else begin
         e.data = to_err ? '0 : fact(n);
         e.err  = to_err;
         exp_starts++;
      end
      sb.push_back(e);
      req_n     = DATA_W'(n);
      req_valid = 1'b1;
      b = 0;
      while (req_ready !== 1'b1 && b < 50) begin
         @(negedge clk);
         b++;
      end
      if (b >= 50) check("req_accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(input int lat);
      exp_t e;
      int   c;
      c = 0;
      while (rsp_valid !== 1'b1 && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (c >= 200) begin
         check("rsp_timeout", 32'd0, 32'd1);
         return;
      end
      if (lat >= 0) check("rsp_latency", 32'(c), 32'(lat));
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      rsp_ready = 1'b1;
      @(negedge clk);
      check("start_cnt", 32'(n_starts), 32'(exp_starts));
      check("rsp_drop", 32'(rsp_valid), 32'd0);
   endtask

   initial begin : main
      #1;
      check("rst_ctl", 32'({req_ready, start, rsp_valid, rsp_ovf, rsp_err}), 32'd0);
      check("rst_dp_din", 32'(dp_din), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rdy_in_rst_win", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rdy_after_rst", 32'(req_ready), 32'd1);

      send(5, 1'b0); get_rsp(dp_lat + 1);
      send(0, 1'b0); get_rsp(0);
      send(1, 1'b0); get_rsp(0);
      send(9, 1'b0); get_rsp(0);
      send(255, 1'b0); get_rsp(0);
      send(8, 1'b0); get_rsp(dp_lat + 1);
      for (int n = 2; n <= 7; n++) begin
         send(n, 1'b0);
         get_rsp(dp_lat + 1);
      end

      // Held response with a done glitch in RESP.
      rsp_ready = 1'b0;
      send(5, 1'b0);
      for (int k = 0; k < 20 && rsp_valid !== 1'b1; k++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) done = 1'b1;
         if (k == 4) done = 1'b0;
         check("hold_data", 32'(rsp_data), 32'd120);
         check("hold_rdy", 32'(req_ready), 32'd0);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      get_rsp(-1);

      // Reset while waiting for done; the model's done later arrives in IDLE.
      send(6, 1'b0);
      @(negedge clk);
      job_killed = 1'b1;
      rst = 1'b1;
      #1;
      check("midrst_ctl", 32'({req_ready, start, rsp_valid, rsp_ovf, rsp_err}), 32'd0);
      check("midrst_dp_din", 32'(dp_din), 32'd0);
      check("midrst_rsp_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      repeat (5) begin
         @(negedge clk);
         check("stray_done", 32'(rsp_valid), 32'd0);
      end
      send(4, 1'b0); get_rsp(dp_lat + 1);

      // done lands on the last possible WAIT cycle.
      dp_lat = TIMEOUT_CYC;
      send(7, 1'b0); get_rsp(TIMEOUT_CYC + 1);
      dp_lat = 3;

`ifdef FACT_TIMEOUT_EN
      dp_mute = 1'b1;
      send(7, 1'b1); get_rsp(TIMEOUT_CYC + 1);
      dp_mute = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("late_done", 32'({rsp_valid, start}), 32'd0);
      end
      send(3, 1'b0); get_rsp(dp_lat + 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/fact_host_issuer.md
# fact_host_issuer

Host-side initiator for the factorial datapath's start/done handshake. The block accepts operand requests on a valid/ready port and drives `start` and the external operand into the datapath controller. It waits for the controller's `done` pulse, captures the datapath output, and returns it on a valid/ready response port. Operands 0, 1 and values above `MAX_N` are answered locally and never launched. An optional watchdog recovers from a missing `done`.

## Interface
Parameters:
- `DATA_W`, default 8: operand width.
- `RES_W`, default 16: result width.
- `MAX_N`, default 8: largest operand launched to the datapath (8! = 40320 fits in 16 bits).
- `TIMEOUT_CYC`, default 64: watchdog limit in cycles; used only when `FACT_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: operand request valid.
- `req_ready`  out  1: request accepted this cycle.
- `req_n`  in  DATA_W: operand.
- `start`  out  1: launch pulse to the datapath controller.
- `dp_din`  out  DATA_W: external operand to the datapath.
- `done`  in  1: completion pulse from the controller.
- `dp_dout`  in  RES_W: datapath result, valid in the `done` cycle.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_data`  out  RES_W: result.
- `rsp_ovf`  out  1: operand exceeded `MAX_N`.
- `rsp_err`  out  1: watchdog expired.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - `req_ready` is 1.
  - On accept with `req_n` ≤ 1: go to RESP with `rsp_data` = 1.
  - On accept with `req_n` > `MAX_N`: go to RESP with `rsp_data` = all-ones and `rsp_ovf` = 1.
  - On accept otherwise: latch the operand and go to LAUNCH.
- LAUNCH:
  - `start` = 1 for exactly one cycle.
  - `dp_din` = latched operand.
  - Next state is WAIT.
- WAIT:
  - `start` = 0; `dp_din` is held.
  - When `done` = 1: capture `dp_dout` into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid` = 1 and all `rsp_*` fields are stable.
  - When `rsp_valid` && `rsp_ready`: go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- `dp_din` is held from LAUNCH until `done` is sampled, because the controller loads it over two consecutive cycles.
- `done` outside WAIT (IDLE, LAUNCH, RESP) is ignored and dropped.
- `start` is never asserted in the cycle `done` is sampled. The earliest re-launch is 3 cycles after `done`: RESP, then IDLE accept, then LAUNCH.
- `rsp_ovf` and `rsp_err` are mutually exclusive and cleared on leaving RESP.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 0 while `rst` is high, 1 from the first cycle after release.
  - `start`, `rsp_valid`, `rsp_ovf`, `rsp_err` = 0.
  - `dp_din`, `rsp_data` = 0.
- Reset mid-operation drops the job. The controller has no reset, so a stray later `done` is ignored per the rule above.
- Launched job latency: accept edge, then 1 cycle to LAUNCH, then the datapath latency, then `rsp_valid` 1 cycle after `done`.
- Bypass latency: `rsp_valid` rises the cycle after accept.
- A response held across multiple cycles while `rsp_ready` = 0 must not change.
- All outputs are registered; there are no combinational paths from `req_*` or `done` to outputs.

## Configuration
- `FACT_TIMEOUT_EN` defined:
  - A watchdog counter starts at 0 in LAUNCH and increments every cycle in WAIT.
  - On reaching `TIMEOUT_CYC` with no `done`: go to RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - A `done` arriving in the same cycle the count reaches `TIMEOUT_CYC` wins: a normal response, `rsp_err` = 0.
- `FACT_TIMEOUT_EN` undefined:
  - No counter is built and `rsp_err` is tied to 0.
  - WAIT waits indefinitely for `done`.

## Structure
- Package `fact_pkg` holds:
  - The state enum.
  - `DATA_W` and `RES_W` defaults.
  - Response-flag constants.
- Sub-module `fact_watchdog` holds the counter with clear and enable inputs and an expire output.
  - Instantiated only under `FACT_TIMEOUT_EN`.
  - Width is `$clog2(TIMEOUT_CYC+1)`.

## Test plan
- `req_n` = 5 with the bench datapath model → one `start` pulse; `dp_din` = 5 until `done`; then `rsp_data` = 120, `rsp_ovf` = 0, `rsp_err` = 0.
- `req_n` = 0, then `req_n` = 1 → no `start` pulse; each yields `rsp_data` = 1 one cycle after accept.
- `req_n` = 9 with `MAX_N` = 8 → no `start` pulse; `rsp_data` = 16'hFFFF, `rsp_ovf` = 1.
- `rsp_ready` held at 0 for 10 cycles after `done` → `rsp_data` stays 120 and `req_ready` stays 0; a `done` glitch injected during RESP changes nothing.
- With `FACT_TIMEOUT_EN` and `TIMEOUT_CYC` = 64, `done` never driven → `rsp_err` = 1, `rsp_data` = 0 at the 64th WAIT cycle. A late `done` in IDLE is ignored, and the next request with `req_n` = 3 returns 6.
- `rst` asserted in WAIT → all outputs return to their reset values immediately. After release, `req_n` = 4 returns 24.
